relay_buzz_seq: RTL and testbench
=================================

# relay_buzz_seq

Command-driven sequencer for the board's relay and buzzer outputs. It accepts one pattern command at a time (on-time, off-time, repeat count, output enables) and plays it out in millisecond units derived from the `osc` clock. A level-sensitive `fault` input overrides everything and forces the safe state (relay open, buzzer sounding). It sits between the control logic and the `Relay`/`Buzz` pins, replacing free-running toggle counters.

## Interface
- `TICK_DIV`, default 50000: `osc` cycles per 1 ms tick (50 MHz `osc`).
- `MS_W`, default 16: width of the on/off time fields, in ms.
- `REP_W`, default 8: width of the repeat-count field.
- `osc` in 1: system clock; all logic rises on `posedge osc`.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_on_ms` in MS_W: on-phase length, in ms.
- `cmd_off_ms` in MS_W: off-phase length, in ms.
- `cmd_reps` in REP_W: number of on-phases.
- `cmd_relay_en` in 1: drive `Relay` during on-phases.
- `cmd_buzz_en` in 1: drive `Buzz` during on-phases.
- `abort` in 1: single-cycle request to cancel the active sequence.
- `fault` in 1: level; forces the safe state while high.
- `Relay` out 1: relay drive, registered.
- `Buzz` out 1: buzzer drive, registered.
- `busy` out 1: a sequence is in progress (ON or OFF state).
- `done` out 1: one-cycle pulse when a sequence completes normally.
- `aborted` out 1: one-cycle pulse when a sequence is cancelled by `abort` or `fault`.

## Operation
- **States:** IDLE, ON, OFF, FAULT.
- **Reset values:** all outputs are 0 and the state is IDLE; the prescaler, ms counter and repeat counter are cleared.
- **`cmd_ready`:** registered. It is 1 in IDLE when `fault` is low, and 0 otherwise. It first rises on the first clock edge after `reset_n` deasserts.
- **Command acceptance:** a command is accepted on a cycle where `cmd_valid` and `cmd_ready` are both 1.
  - All fields are latched on acceptance.
  - If `cmd_on_ms` is 0 or `cmd_reps` is 0, the command is a null command: `done` pulses on the next cycle, the state stays IDLE, and the outputs stay 0.
  - Otherwise the state goes to ON.
- **ON:**
  - `Relay` = `relay_en`; `Buzz` = `buzz_en`.
  - After `on_ms` ticks the repeat counter increments.
  - If the repeat counter then equals `reps`: go to IDLE and pulse `done`.
  - Else if `off_ms` is 0: re-enter ON, so the outputs stay high continuously.
  - Else: go to OFF.
- **OFF:** `Relay` and `Buzz` are 0. After `off_ms` ticks, go to ON.
- **Tick prescaler:**
  - Counts 0..TICK_DIV-1 and issues a tick when the count reaches TICK_DIV-1.
  - It is cleared on every entry into ON or OFF, so each phase lasts exactly ms × TICK_DIV cycles.
  - The ms counter width is MS_W. The comparison is `ms_cnt == len-1` qualified by the tick, so there is no wrap.
- **`abort`:** in ON or OFF, go to IDLE and pulse `aborted`. In IDLE, `abort` is ignored.
- **`fault` high:** from any state, go to FAULT. `Relay` = 0, `Buzz` = 1. If the state was ON or OFF, pulse `aborted`; the latched command is discarded.
- **`fault` low while in FAULT:** go to IDLE with outputs 0. Commands are not resumed.
- **Priority:** `fault` > `abort` > phase completion > command acceptance.
- **`abort` on the final-tick cycle:** `abort` wins; `aborted` pulses and `done` does not.

## Timing
- **Command accepted at edge T:** `busy`, `Relay`/`Buzz` and the ON state are all visible after edge T+1. `cmd_ready` falls after T+1.
- **Phase lengths:** an ON phase holds its outputs for exactly on_ms × TICK_DIV cycles. An OFF phase holds 0 for exactly off_ms × TICK_DIV cycles.
- **Normal completion:** on the cycle after the last ON tick, the outputs are 0, `done` = 1 and `busy` = 0. `cmd_ready` = 1 on that same cycle.
- **Abort/fault response:** 1 cycle to the outputs and the `aborted` pulse.
- **Back-to-back commands:** a new command can be accepted on the first cycle `cmd_ready` = 1. There is no dead cycle beyond that.

## Structure
- **Package `relay_buzz_pkg`:** holds the state enum (IDLE, ON, OFF, FAULT) and the default TICK_DIV, MS_W and REP_W constants.
- **Sub-module `ms_tick_gen`:** the prescaler, with a synchronous clear input and a tick output. It is reused by other timed blocks.
- **Top FSM:** contains the FSM, the ms counter, the repeat counter and the registered outputs. Target size is about 200 lines of RTL.

## Test plan
The bench uses TICK_DIV = 4.
- **Reset:** hold `reset_n`=0 mid-sequence → all outputs 0 immediately. After release, `cmd_ready`=1 one cycle later.
- **Basic pattern:** on=2, off=1, reps=3, relay_en=1, buzz_en=0 → `Relay` is high for 8 cycles, low for 4, repeated 3 times (no trailing OFF). `done` pulses on the cycle after the third ON phase. `Buzz` stays 0 throughout.
- **Null command:** reps=0 or on=0 → `done` the next cycle, `busy` never 1, outputs 0.
- **Continuous on:** off=0, on=1, reps=5 → `Relay` high for exactly 20 contiguous cycles, then `done`.
- **Abort:** `abort` during the second OFF phase → IDLE next cycle, `aborted`=1, no `done`. Repeat with `abort` on the final tick cycle → `aborted` only, no `done`.
- **Fault:** `fault` held for 10 cycles mid-ON → `Relay`=0, `Buzz`=1 one cycle later, `aborted` pulses, `cmd_ready`=0. After `fault` drops → IDLE, outputs 0, and the old sequence does not resume.

Source files
------------

// File: rtl/relay_buzz_pkg.sv
// rtl/relay_buzz_pkg.sv - shared state encoding and default sizing for the relay/buzzer sequencer
package relay_buzz_pkg;

  localparam int DEF_TICK_DIV = 50000;
  localparam int DEF_MS_W     = 16;
  localparam int DEF_REP_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2,
    ST_FAULT = 2'd3
  } seq_state_t;

  function automatic logic is_active(input seq_state_t s);
    return (s == ST_ON) || (s == ST_OFF);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler with synchronous clear
// tick is high on the last count of each TICK_DIV-cycle period.
module ms_tick_gen
  import relay_buzz_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic osc,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge osc or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/relay_buzz_seq.sv
// rtl/relay_buzz_seq.sv - command-driven relay/buzzer pattern sequencer
// All outputs are registered from the next-state decode so they move together.
module relay_buzz_seq
  import relay_buzz_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int MS_W     = DEF_MS_W,
  parameter int REP_W    = DEF_REP_W
) (
  input  logic             osc,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [MS_W-1:0]  cmd_on_ms,
  input  logic [MS_W-1:0]  cmd_off_ms,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             cmd_relay_en,
  input  logic             cmd_buzz_en,
  input  logic             abort,
  input  logic             fault,
  output logic             Relay,
  output logic             Buzz,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  seq_state_t state, state_n;

  logic [MS_W-1:0]  on_len, off_len, ms_cnt;
  logic [REP_W-1:0] reps, rep_cnt;
  logic             relay_en, buzz_en;

  logic tick, pres_clr, is_null, rep_last;
  logic accept, phase_end, on_end;
  logic done_n, aborted_n, relay_n, buzz_n;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .osc     (osc),
    .reset_n (reset_n),
    .clr     (pres_clr),
    .tick    (tick)
  );

  assign is_null  = (cmd_on_ms == '0) || (cmd_reps == '0);
  assign rep_last = ((rep_cnt + REP_W'(1)) == reps);

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    phase_end = 1'b0;
    on_end    = 1'b0;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    relay_n   = 1'b0;
    buzz_n    = 1'b0;
    pres_clr  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept = 1'b1;
          if (is_null) begin
            done_n = 1'b1;
          end else begin
            state_n = ST_ON;
          end
        end
      end
      ST_ON: begin
        if (abort) begin
          state_n   = ST_IDLE;
          aborted_n = 1'b1;
        end else if (tick && (ms_cnt == on_len - MS_W'(1))) begin
          phase_end = 1'b1;
          on_end    = 1'b1;
          if (rep_last) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else if (off_len == '0) begin
            state_n = ST_ON;
          end else begin
            state_n = ST_OFF;
          end
        end
      end
      ST_OFF: begin
        if (abort) begin
          state_n   = ST_IDLE;
          aborted_n = 1'b1;
        end else if (tick && (ms_cnt == off_len - MS_W'(1))) begin
          phase_end = 1'b1;
          state_n   = ST_ON;
        end
      end
      ST_FAULT: begin
        if (!fault) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // fault outranks everything, including a completion on this same cycle
    if (fault) begin
      state_n   = ST_FAULT;
      accept    = 1'b0;
      phase_end = 1'b0;
      on_end    = 1'b0;
      done_n    = 1'b0;
      aborted_n = is_active(state);
    end

    // restart the prescaler whenever a phase (re)starts so every phase is whole
    pres_clr = phase_end || (state_n != state) || !is_active(state_n);

    relay_n = (state_n == ST_ON) && (accept ? cmd_relay_en : relay_en);
    buzz_n  = (state_n == ST_FAULT) ||
              ((state_n == ST_ON) && (accept ? cmd_buzz_en : buzz_en));
  end

  always_ff @(posedge osc or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      Relay     <= 1'b0;
      Buzz      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_n;
      Relay     <= relay_n;
      Buzz      <= buzz_n;
      busy      <= is_active(state_n);
      done      <= done_n;
      aborted   <= aborted_n;
      cmd_ready <= (state_n == ST_IDLE);
    end
  end

  always_ff @(posedge osc or negedge reset_n) begin
    if (!reset_n) begin
      ms_cnt   <= '0;
      rep_cnt  <= '0;
      on_len   <= '0;
      off_len  <= '0;
      reps     <= '0;
      relay_en <= 1'b0;
      buzz_en  <= 1'b0;
    end else begin
      if (pres_clr) begin
        ms_cnt <= '0;
      end else if (tick) begin
        ms_cnt <= ms_cnt + MS_W'(1);
      end

      if (fault) begin
        on_len   <= '0;
        off_len  <= '0;
        reps     <= '0;
        relay_en <= 1'b0;
        buzz_en  <= 1'b0;
        rep_cnt  <= '0;
      end else if (accept) begin
        on_len   <= cmd_on_ms;
        off_len  <= cmd_off_ms;
        reps     <= cmd_reps;
        relay_en <= cmd_relay_en;
        buzz_en  <= cmd_buzz_en;
        rep_cnt  <= '0;
      end else if (on_end) begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_relay_buzz_seq.sv
// tb/tb_relay_buzz_seq.sv - self-checking bench for relay_buzz_seq
// Model expands each command into a per-cycle output timeline and replays it.
module tb_relay_buzz_seq;

  localparam int TD    = 4;
  localparam int MS_W  = 16;
  localparam int REP_W = 8;

  logic             osc = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [MS_W-1:0]  cmd_on_ms = '0;
  logic [MS_W-1:0]  cmd_off_ms = '0;
  logic [REP_W-1:0] cmd_reps = '0;
  logic             cmd_relay_en = 1'b0;
  logic             cmd_buzz_en = 1'b0;
  logic             abort = 1'b0;
  logic             fault = 1'b0;
  logic             cmd_ready, Relay, Buzz, busy, done, aborted;

  int checks = 0;
  int failures = 0;

  always #5 osc = ~osc;

  relay_buzz_seq #(
    .TICK_DIV(TD),
    .MS_W(MS_W),
    .REP_W(REP_W)
  ) dut (
    .osc          (osc),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_on_ms    (cmd_on_ms),
    .cmd_off_ms   (cmd_off_ms),
    .cmd_reps     (cmd_reps),
    .cmd_relay_en (cmd_relay_en),
    .cmd_buzz_en  (cmd_buzz_en),
    .abort        (abort),
    .fault        (fault),
    .Relay        (Relay),
    .Buzz         (Buzz),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  // expected {Relay, Buzz, busy, done, aborted, cmd_ready} for the current cycle
  logic [5:0] exp_v = '0;
  logic [1:0] sched[$];
  bit         cur_busy = 0;
  bit         in_fault = 0;

  task automatic model_step();
    logic       ready_now;
    logic [1:0] o;
    int         reps_i, on_c, off_c;
    ready_now = exp_v[0];
    if (fault) begin
      exp_v = {1'b0, 1'b1, 1'b0, 1'b0, cur_busy, 1'b0};
      sched.delete();
      cur_busy = 0;
      in_fault = 1;
    end else if (in_fault) begin
      in_fault = 0;
      exp_v = 6'b000001;
    end else if (cur_busy) begin
      if (abort) begin
        sched.delete();
        cur_busy = 0;
        exp_v = 6'b000011;
      end else if (sched.size() > 0) begin
        o = sched.pop_front();
        exp_v = {o, 1'b1, 3'b000};
      end else begin
        cur_busy = 0;
        exp_v = 6'b000101;
      end
    end else if (cmd_valid && ready_now) begin
      if (cmd_on_ms == 0 || cmd_reps == 0) begin
        exp_v = 6'b000101;
      end else begin
        reps_i = int'(cmd_reps);
        on_c   = int'(cmd_on_ms) * TD;
        off_c  = int'(cmd_off_ms) * TD;
        for (int r = 0; r < reps_i; r++) begin
          for (int c = 0; c < on_c; c++) sched.push_back({cmd_relay_en, cmd_buzz_en});
          if (r < reps_i - 1)
            for (int c = 0; c < off_c; c++) sched.push_back(2'b00);
        end
        o = sched.pop_front();
        cur_busy = 1;
        exp_v = {o, 1'b1, 3'b000};
      end
    end else begin
      exp_v = 6'b000001;
    end
  endtask

  initial forever begin
    @(posedge osc or negedge reset_n);
    if (!reset_n) begin
      sched.delete();
      cur_busy = 0;
      in_fault = 0;
      exp_v = '0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge osc);
    checks++;
    if ({Relay, Buzz, busy, done, aborted, cmd_ready} !== exp_v) begin
      failures++;
      $display("FAIL cycle_compare t=%0t got={R,B,busy,done,abt,rdy}=%b want=%b",
               $time, {Relay, Buzz, busy, done, aborted, cmd_ready}, exp_v);
    end
  end

  int m_relay, m_buzz, m_busy, m_done, m_abt, m_notready, m_run, m_max;

  task automatic clear_mon();
    m_relay = 0; m_buzz = 0; m_busy = 0; m_done = 0;
    m_abt = 0; m_notready = 0; m_run = 0; m_max = 0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge osc);
      if (Relay === 1'b1) m_relay++;
      if (Buzz === 1'b1) m_buzz++;
      if (busy === 1'b1) m_busy++;
      if (done === 1'b1) m_done++;
      if (aborted === 1'b1) m_abt++;
      if (cmd_ready !== 1'b1) m_notready++;
      m_run = (Relay === 1'b1) ? m_run + 1 : 0;
      if (m_run > m_max) m_max = m_run;
    end
  endtask

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic send(input int on_ms, input int off_ms, input int reps,
                      input logic ren, input logic ben);
    @(negedge osc);
    cmd_on_ms    = MS_W'(on_ms);
    cmd_off_ms   = MS_W'(off_ms);
    cmd_reps     = REP_W'(reps);
    cmd_relay_en = ren;
    cmd_buzz_en  = ben;
    cmd_valid    = 1'b1;
    @(posedge osc);
    #1 cmd_valid = 1'b0;
    clear_mon();
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge osc);
    #1 abort = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    repeat (3) @(negedge osc);
    lit("reset_ready_low", int'(cmd_ready), 0);
    reset_n = 1'b1;
    #1 lit("ready_before_edge", int'(cmd_ready), 0);
    run_cycles(1);
    lit("ready_after_release", int'(cmd_ready), 1);

    send(2, 1, 3, 1'b1, 1'b0);
    run_cycles(40);
    lit("basic_relay_cycles", m_relay, 24);
    lit("basic_buzz_cycles", m_buzz, 0);
    lit("basic_busy_cycles", m_busy, 32);
    lit("basic_done", m_done, 1);
    lit("basic_max_run", m_max, 8);

    send(0, 3, 2, 1'b1, 1'b1);
    run_cycles(4);
    lit("null_on_done", m_done, 1);
    lit("null_on_busy", m_busy, 0);
    send(2, 1, 0, 1'b1, 1'b0);
    run_cycles(4);
    lit("null_reps_done", m_done, 1);
    lit("null_reps_relay", m_relay, 0);

    send(1, 0, 5, 1'b1, 1'b0);
    run_cycles(30);
    lit("cont_relay_cycles", m_relay, 20);
    lit("cont_max_run", m_max, 20);
    lit("cont_done", m_done, 1);

    send(2, 1, 3, 1'b1, 1'b1);
    run_cycles(21);
    lit("abort_pre_relay", m_relay, 16);
    pulse_abort();
    clear_mon();
    run_cycles(10);
    lit("abort_off_aborted", m_abt, 1);
    lit("abort_off_done", m_done, 0);
    lit("abort_off_busy", m_busy, 0);

    send(1, 1, 2, 1'b1, 1'b0);
    run_cycles(12);
    lit("abort_last_pre_relay", m_relay, 8);
    pulse_abort();
    clear_mon();
    run_cycles(6);
    lit("abort_last_aborted", m_abt, 1);
    lit("abort_last_done", m_done, 0);

    pulse_abort();
    clear_mon();
    run_cycles(3);
    lit("abort_idle_ignored", m_abt, 0);

    send(3, 1, 2, 1'b1, 1'b0);
    run_cycles(5);
    fault = 1'b1;
    clear_mon();
    run_cycles(10);
    lit("fault_buzz_cycles", m_buzz, 10);
    lit("fault_relay_cycles", m_relay, 0);
    lit("fault_aborted", m_abt, 1);
    lit("fault_not_ready", m_notready, 10);
    fault = 1'b0;
    clear_mon();
    run_cycles(30);
    lit("post_fault_relay", m_relay, 0);
    lit("post_fault_busy", m_busy, 0);
    lit("post_fault_done", m_done, 0);

    send(2, 1, 3, 1'b1, 1'b1);
    run_cycles(3);
    #2 reset_n = 1'b0;
    #1 lit("reset_async_outs", int'({Relay, Buzz, busy}), 0);
    repeat (2) @(negedge osc);
    reset_n = 1'b1;
    #1 lit("reset_ready_pre", int'(cmd_ready), 0);
    run_cycles(1);
    lit("reset_ready_post", int'(cmd_ready), 1);

    send(1, 0, 1, 1'b0, 1'b1);
    run_cycles(6);
    lit("final_buzz_cycles", m_buzz, 4);
    lit("final_done", m_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
